divs_iter: RTL and testbench

DIVS_ITER -- requirements
Module: divs_iter

---
 rtl/divs_iter.sv | 158 +++++++++++++++
 tb/tb_divs_iter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/divs_iter.sv
// divs_iter: 32-bit signed iterative divider (restoring, one quotient bit per cycle).
// Latency: done pulses 34 cycles after an accepted start (1 cycle for divide-by-zero).
// Backpressure: none; start is only honoured while idle, otherwise ignored.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start, a, b       - request with dividend/divisor, captured when accepted in IDLE
//   q, r              - quotient (toward zero) and remainder (sign of dividend)
//   n, z, dbz         - quotient negative, quotient zero, divide-by-zero flags
//   busy, done        - operation in progress; one-cycle completion pulse
module divs_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        n,
  output logic        z,
  output logic        dbz,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] rem_q, rem_d;     // partial remainder (upper half of shift register)
  logic [31:0] quo_q, quo_d;     // dividend bits shifting out / quotient bits shifting in
  logic [31:0] bmag_q, bmag_d;   // |b| as unsigned
  logic        sa_q, sa_d;       // sign of dividend, applied to remainder
  logic        sq_q, sq_d;       // sign of quotient
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;
  logic        z_q, z_d;
  logic        dbz_q, dbz_d;
  logic        done_q, done_d;

  logic [31:0] a_mag, b_mag;
  logic [31:0] shift_hi;
  logic [32:0] trial;
  logic [31:0] q_fix, r_fix;

  // 32'h80000000 maps to unsigned 2^31, which fits the 32-bit magnitude path.
  assign a_mag = a[31] ? (~a + 32'd1) : a;
  assign b_mag = b[31] ? (~b + 32'd1) : b;

  // Upper half after the left shift. rem_q < |b| <= 2^31, so its MSB is always
  // zero and dropping it loses nothing.
  assign shift_hi = {rem_q[30:0], quo_q[31]};
  assign trial    = {1'b0, shift_hi} - {1'b0, bmag_q};

  assign q_fix = sq_q ? (~quo_q + 32'd1) : quo_q;
  assign r_fix = sa_q ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    bmag_d  = bmag_q;
    sa_d    = sa_q;
    sq_d    = sq_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    z_d     = z_q;
    dbz_d   = dbz_q;
    // done is registered from the DONE state, so it appears one cycle after
    // the results were loaded and coincides with the return to IDLE.
    done_d  = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (b == 32'd0) begin
            state_d = DONE;
            q_d     = 32'hFFFF_FFFF;
            r_d     = a;
            z_d     = 1'b0;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            rem_d   = 32'd0;
            quo_d   = a_mag;
            bmag_d  = b_mag;
            sa_d    = a[31];
            sq_d    = a[31] ^ b[31];
            cnt_d   = 5'd0;
          end
        end
      end
      CALC: begin
        // Restore on a negative trial, otherwise keep it and shift in a 1.
        rem_d = trial[32] ? shift_hi : trial[31:0];
        quo_d = {quo_q[30:0], ~trial[32]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FIX;
        end
      end
      FIX: begin
        q_d     = q_fix;
        r_d     = r_fix;
        z_d     = (q_fix == 32'd0);
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      bmag_q  <= 32'd0;
      sa_q    <= 1'b0;
      sq_q    <= 1'b0;
      cnt_q   <= 5'd0;
      q_q     <= 32'd0;
      r_q     <= 32'd0;
      z_q     <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      bmag_q  <= bmag_d;
      sa_q    <= sa_d;
      sq_q    <= sq_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      z_q     <= z_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  // z is kept as a register loaded alongside q so it reads low out of reset
  // even though q is zero then; it always equals (q == 0) after a completion.
  assign q    = q_q;
  assign r    = r_q;
  assign n    = q_q[31];
  assign z    = z_q;
  assign dbz  = dbz_q;
  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = done_q;

endmodule

// File: tb/tb_divs_iter.sv
// tb_divs_iter: bench for divs_iter.
// Reference model tracks accepted requests and completion timing; results come
// from plain signed arithmetic.
module tb_divs_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic [31:0] q, r;
  logic        n, z, dbz, busy, done;

  divs_iter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .n     (n),
    .z     (z),
    .dbz   (dbz),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit          mvalid = 1'b0;
  int          ph     = -1;   // cycles since acceptance, -1 when idle
  int          lat    = 0;
  logic [31:0] pend_q, pend_r;
  logic        pend_dbz;
  logic [31:0] pub_q = '0, pub_r = '0;
  logic        pub_dbz = 1'b0, pub_z = 1'b0;
  logic        exp_done = 1'b0, exp_busy = 1'b0;

  function automatic void model_div(input logic [31:0] av, input logic [31:0] bv);
    longint sa, sb, qq, rr;
    if (bv == 32'd0) begin
      pend_q   = 32'hFFFF_FFFF;
      pend_r   = av;
      pend_dbz = 1'b1;
    end else begin
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      qq = sa / sb;
      rr = sa % sb;
      pend_q   = qq[31:0];
      pend_r   = rr[31:0];
      pend_dbz = 1'b0;
    end
  endfunction

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      mvalid   = 1'b1;
      ph       = -1;
      pub_q    = '0;
      pub_r    = '0;
      pub_dbz  = 1'b0;
      pub_z    = 1'b0;
      exp_done = 1'b0;
    end else if (mvalid) begin
      exp_done = 1'b0;
      if (ph >= 0) begin
        ph++;
        if (ph == lat) begin
          exp_done = 1'b1;
          pub_q    = pend_q;
          pub_r    = pend_r;
          pub_dbz  = pend_dbz;
          pub_z    = (pend_q == 32'd0);
          ph       = -1;
        end
      end else if (start === 1'b1) begin
        model_div(a, b);
        ph  = 0;
        lat = (b == 32'd0) ? 1 : 34;
      end
    end
    exp_busy = (ph >= 0) && (lat == 34) && (ph <= 32);
  end

  // Every-cycle comparison. Result outputs are skipped only in the single
  // cycle where the DUT has loaded new results but not yet pulsed done.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("done", {31'd0, done}, {31'd0, exp_done});
      if ((ph == -1) || (lat == 34 && ph <= 32)) begin
        chk("q",   q, pub_q);
        chk("r",   r, pub_r);
        chk("n",   {31'd0, n},   {31'd0, pub_q[31]});
        chk("z",   {31'd0, z},   {31'd0, pub_z});
        chk("dbz", {31'd0, dbz}, {31'd0, pub_dbz});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_done(input string nm);
    int t = 0;
    while (done !== 1'b1 && t < 80) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic op(input string nm, input logic [31:0] av, input logic [31:0] bv,
                    input logic [31:0] eq, input logic [31:0] er, input int elat);
    int k;
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1 k = cyc;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;   // must not disturb the operation in flight
    b     = $urandom;
    wait_done(nm);
    chk({nm, "_lat"}, cyc - k, elat);
    chk({nm, "_q"}, q, eq);
    chk({nm, "_r"}, r, er);
    chk({nm, "_n"}, {31'd0, n}, {31'd0, eq[31]});
    chk({nm, "_z"}, {31'd0, z}, {31'd0, (eq == 32'd0)});
    chk({nm, "_dbz"}, {31'd0, dbz}, {31'd0, (bv == 32'd0)});
  endtask

  initial begin
    int k1, k2, ndone;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_q", q, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_z", {31'd0, z}, 32'd0);
    rst = 1'b0;

    op("p100_7",   32'd100,        32'd7,          32'd14,         32'd2,          34);
    op("m100_7",   32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  34);
    op("p100_m7",  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          34);
    op("div0",     32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1);
    op("ovf",      32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          34);
    op("p3_10",    32'd3,          32'd10,         32'd0,          32'd3,          34);
    op("max_min",  32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          32'h7FFF_FFFF,  34);
    op("m7_m2",    32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  34);

    // Abort: start 1000/10, stray start mid-operation, reset at cycle 20.
    @(negedge clk);
    start = 1'b1; a = 32'd1000; b = 32'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_q", q, 32'd0);
    chk("abort_r", r, 32'd0);
    chk("abort_n", {31'd0, n}, 32'd0);
    chk("abort_z", {31'd0, z}, 32'd0);
    chk("abort_dbz", {31'd0, dbz}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);
    op("restart", 32'd1000, 32'd10, 32'd100, 32'd0, 34);

    // Back-to-back with start held high throughout.
    @(negedge clk);
    start = 1'b1; a = 32'd20; b = 32'd3;
    @(posedge clk);
    #1 k1 = cyc;
    @(negedge clk);
    wait_done("b2b1");
    chk("b2b1_lat", cyc - k1, 32'd34);
    chk("b2b1_q", q, 32'd6);
    chk("b2b1_r", r, 32'd2);
    a = 32'hFFFF_FFEC;
    b = 32'd3;
    @(posedge clk);
    #1 k2 = cyc;
    chk("b2b_accept_gap", k2 - k1, 32'd35);
    @(negedge clk);
    wait_done("b2b2");
    start = 1'b0;
    chk("b2b2_lat", cyc - k2, 32'd34);
    chk("b2b2_q", q, 32'hFFFF_FFFA);
    chk("b2b2_r", r, 32'hFFFF_FFFE);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
